// File: rtl/rop3_blit_if.sv
// Command, memory and rop3-unit connections of the ROP3 blit sequencer.
// The master modport is the sequencer; the slave modport is the host/memory/rop3 side.
interface rop3_blit_if #(
    parameter int N  = 8,
    parameter int AW = 8
);
    logic          start;
    logic          abort;
    logic [7:0]    mode;
    logic [N-1:0]  pattern;
    logic [AW-1:0] src_base;
    logic [AW-1:0] dst_base;
    logic [AW-1:0] len;

    logic          busy;
    logic          done;
    logic          aborted;
    logic [AW-1:0] words_done;

    logic          src_re;
    logic [AW-1:0] src_addr;
    logic [N-1:0]  src_rdata;
    logic          dst_re;
    logic [AW-1:0] dst_raddr;
    logic [N-1:0]  dst_rdata;

    logic [N-1:0]  rop_P;
    logic [N-1:0]  rop_S;
    logic [N-1:0]  rop_D;
    logic [7:0]    rop_Mode;
    logic [N-1:0]  rop_Result;

    logic          dst_we;
    logic [AW-1:0] dst_waddr;
    logic [N-1:0]  dst_wdata;

    modport master (
        input  start, abort, mode, pattern, src_base, dst_base, len,
        input  src_rdata, dst_rdata, rop_Result,
        output busy, done, aborted, words_done,
        output src_re, src_addr, dst_re, dst_raddr,
        output rop_P, rop_S, rop_D, rop_Mode,
        output dst_we, dst_waddr, dst_wdata
    );

    modport slave (
        output start, abort, mode, pattern, src_base, dst_base, len,
        output src_rdata, dst_rdata, rop_Result,
        input  busy, done, aborted, words_done,
        input  src_re, src_addr, dst_re, dst_raddr,
        input  rop_P, rop_S, rop_D, rop_Mode,
        input  dst_we, dst_waddr, dst_wdata
    );
endinterface

// File: rtl/rop3_blit_ctrl.sv
// Sequencer running one ROP3 operation over a linear span: reads S and D, feeds the
// registered rop3 unit, and writes each Result back to D three cycles after the read.
module rop3_blit_ctrl #(
    parameter int N  = 8,
    parameter int AW = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    rop3_blit_if.master bus
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

    localparam logic [AW-1:0] ONE = AW'(1);

    state_t        state;
    state_t        state_next;

    logic [7:0]    mode_q;
    logic [N-1:0]  pattern_q;
    logic [AW-1:0] src_base_q;
    logic [AW-1:0] dst_base_q;
    logic [AW-1:0] len_q;

    logic [AW-1:0] rd_idx;
    logic [AW-1:0] words_q;
    logic          aborted_q;

    logic [2:0]    pipe_v;
    logic [AW-1:0] idx_s1;
    logic [AW-1:0] idx_s2;
    logic [AW-1:0] idx_s3;

    logic          accept;
    logic          kill;
    logic          issue;
    logic          last_issue;
    logic          write_en;

    always_comb begin
        accept     = (state == IDLE) && bus.start;
        kill       = ((state == RUN) || (state == DRAIN)) && bus.abort;
        issue      = (state == RUN) && !kill;
        last_issue = issue && (rd_idx == (len_q - ONE));
        write_en   = pipe_v[2] && !kill;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // DRAIN may leave once only the final write stage is occupied: that write lands this cycle.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = (bus.len == '0) ? FIN : RUN;
                end
            end
            RUN: begin
                if (kill) begin
                    state_next = FIN;
                end else if (last_issue) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (kill || (pipe_v[1:0] == 2'b00)) begin
                    state_next = FIN;
                end
            end
            FIN: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q     <= '0;
            pattern_q  <= '0;
            src_base_q <= '0;
            dst_base_q <= '0;
            len_q      <= '0;
        end else if (accept && (bus.len != '0)) begin
            mode_q     <= bus.mode;
            pattern_q  <= bus.pattern;
            src_base_q <= bus.src_base;
            dst_base_q <= bus.dst_base;
            len_q      <= bus.len;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_idx    <= '0;
            words_q   <= '0;
            aborted_q <= 1'b0;
        end else if (accept) begin
            rd_idx    <= '0;
            words_q   <= '0;
            aborted_q <= 1'b0;
        end else begin
            if (issue) begin
                rd_idx <= rd_idx + ONE;
            end
            if (write_en) begin
                words_q <= words_q + ONE;
            end
            if (kill) begin
                aborted_q <= 1'b1;
            end
        end
    end

    // Valid/index shift register: stage 1 = memory data, stage 3 = rop3 Result ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_v <= '0;
            idx_s1 <= '0;
            idx_s2 <= '0;
            idx_s3 <= '0;
        end else begin
            pipe_v <= kill ? 3'b000 : {pipe_v[1:0], issue};
            idx_s1 <= rd_idx;
            idx_s2 <= idx_s1;
            idx_s3 <= idx_s2;
        end
    end

    assign bus.busy       = (state == RUN) || (state == DRAIN);
    assign bus.done       = (state == FIN);
    assign bus.aborted    = (state == FIN) && aborted_q;
    assign bus.words_done = words_q;

    assign bus.src_re     = issue;
    assign bus.dst_re     = issue;
    assign bus.src_addr   = issue ? (src_base_q + rd_idx) : '0;
    assign bus.dst_raddr  = issue ? (dst_base_q + rd_idx) : '0;

    // Memory data is only forwarded while it belongs to a live read, so idle outputs stay 0.
    assign bus.rop_P      = pattern_q;
    assign bus.rop_Mode   = mode_q;
    assign bus.rop_S      = pipe_v[0] ? bus.src_rdata : '0;
    assign bus.rop_D      = pipe_v[0] ? bus.dst_rdata : '0;

    assign bus.dst_we     = write_en;
    assign bus.dst_waddr  = write_en ? (dst_base_q + idx_s3) : '0;
    assign bus.dst_wdata  = write_en ? bus.rop_Result : '0;

endmodule

// File: tb/tb_rop3_blit_ctrl.sv
// Bench for rop3_blit_ctrl: memories and a 2-cycle rop3 unit around the DUT, a queue
// model of expected reads/writes/done timing, and directed commands with literal results.
module tb_rop3_blit_ctrl;

    localparam int N  = 8;
    localparam int AW = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    rop3_blit_if #(.N(N), .AW(AW)) bus ();

    rop3_blit_ctrl #(.N(N), .AW(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [7:0] a;
        logic [7:0] b;
    } ent_t;

    logic [7:0] src_mem [256];
    logic [7:0] dst_mem [256];
    logic [7:0] rop_r1;

    ent_t rdq [$];
    ent_t wrq [$];

    int cyc        = 0;
    int done_cyc   = -1;
    int busy_from  = -1;
    int exp_words  = 0;
    int cmd_s      = 0;
    int cmd_n      = 0;
    bit exp_ab     = 1'b0;
    bit checking   = 1'b0;

    int vectors     = 0;
    int miscompares = 0;

    function automatic logic [7:0] rop3(input logic [7:0] p, input logic [7:0] s,
                                        input logic [7:0] d, input logic [7:0] m);
        logic [7:0] r;
        for (int b = 0; b < 8; b++) begin
            r[b] = m[{p[b], s[b], d[b]}];
        end
        return r;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous-read memories and the two-register rop3 unit the sequencer drives.
    always @(posedge clk) begin
        if (bus.src_re) bus.src_rdata <= src_mem[bus.src_addr];
        if (bus.dst_re) bus.dst_rdata <= dst_mem[bus.dst_raddr];
        if (bus.dst_we) dst_mem[bus.dst_waddr] = bus.dst_wdata;
        rop_r1         <= rop3(bus.rop_P, bus.rop_S, bus.rop_D, bus.rop_Mode);
        bus.rop_Result <= rop_r1;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Read i is issued s+1+i, its write lands s+4+i, done follows the last write.
    task automatic planCommand(input int s, input logic [7:0] m, input logic [7:0] p,
                               input logic [7:0] sb, input logic [7:0] db, input int n);
        logic [7:0] sa;
        logic [7:0] da;
        cmd_s     = s;
        cmd_n     = n;
        exp_ab    = 1'b0;
        exp_words = n;
        busy_from = s + 1;
        done_cyc  = (n > 0) ? (s + n + 4) : (s + 1);
        for (int i = 0; i < n; i++) begin
            sa = 8'(sb + i);
            da = 8'(db + i);
            rdq.push_back('{cyc: s + 1 + i, a: sa, b: da});
            wrq.push_back('{cyc: s + 4 + i, a: da, b: rop3(p, src_mem[sa], dst_mem[da], m)});
        end
    endtask

    task automatic planAbort(input int c);
        int w;
        w = c - cmd_s - 4;
        if (w < 0) w = 0;
        if (w > cmd_n) w = cmd_n;
        exp_words = w;
        exp_ab    = 1'b1;
        done_cyc  = c + 1;
        while (rdq.size() > 0 && rdq[$].cyc >= c) void'(rdq.pop_back());
        while (wrq.size() > 0 && wrq[$].cyc >= c) void'(wrq.pop_back());
    endtask

    task automatic resetModel();
        rdq.delete();
        wrq.delete();
        done_cyc  = -1;
        busy_from = -1;
        exp_ab    = 1'b0;
        exp_words = 0;
    endtask

    always @(negedge clk) begin
        if (checking && rst_n) begin
            bit er;
            bit ew;
            bit ed;
            while (rdq.size() > 0 && rdq[0].cyc < cyc) begin
                checkOutput("read_issue_cycle", cyc, rdq[0].cyc);
                void'(rdq.pop_front());
            end
            while (wrq.size() > 0 && wrq[0].cyc < cyc) begin
                checkOutput("write_cycle", cyc, wrq[0].cyc);
                void'(wrq.pop_front());
            end
            er = (rdq.size() > 0) && (rdq[0].cyc == cyc);
            checkOutput("src_re", bus.src_re, er);
            checkOutput("dst_re", bus.dst_re, er);
            if (er) begin
                checkOutput("src_addr", bus.src_addr, rdq[0].a);
                checkOutput("dst_raddr", bus.dst_raddr, rdq[0].b);
                void'(rdq.pop_front());
            end
            ew = (wrq.size() > 0) && (wrq[0].cyc == cyc);
            checkOutput("dst_we", bus.dst_we, ew);
            if (ew) begin
                checkOutput("dst_waddr", bus.dst_waddr, wrq[0].a);
                checkOutput("dst_wdata", bus.dst_wdata, wrq[0].b);
                void'(wrq.pop_front());
            end
            ed = (cyc == done_cyc);
            checkOutput("done", bus.done, ed);
            checkOutput("busy", bus.busy, (cyc >= busy_from) && (cyc < done_cyc));
            checkOutput("aborted", bus.aborted, ed && exp_ab);
            if (ed) checkOutput("words_done", bus.words_done, exp_words);
        end
    end

    task automatic applyStimulus(input logic [7:0] m, input logic [7:0] p, input logic [7:0] sb,
                                 input logic [7:0] db, input logic [7:0] n);
        bus.mode     = m;
        bus.pattern  = p;
        bus.src_base = sb;
        bus.dst_base = db;
        bus.len      = n;
        bus.start    = 1'b1;
        planCommand(cyc, m, p, sb, db, int'(n));
        tick();
        bus.start = 1'b0;
    endtask

    task automatic waitDone(input int limit, output int lat);
        int k;
        k = 0;
        while (bus.done !== 1'b1 && k < limit) begin
            tick();
            k++;
        end
        lat = cyc - cmd_s;
        if (bus.done !== 1'b1) checkOutput("done_timeout", bus.done, 1);
        tick();
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_busy"}, bus.busy, 0);
        checkOutput({tag, "_done"}, bus.done, 0);
        checkOutput({tag, "_aborted"}, bus.aborted, 0);
        checkOutput({tag, "_words_done"}, bus.words_done, 0);
        checkOutput({tag, "_src_re"}, bus.src_re, 0);
        checkOutput({tag, "_dst_re"}, bus.dst_re, 0);
        checkOutput({tag, "_dst_we"}, bus.dst_we, 0);
        checkOutput({tag, "_src_addr"}, bus.src_addr, 0);
        checkOutput({tag, "_dst_raddr"}, bus.dst_raddr, 0);
        checkOutput({tag, "_dst_waddr"}, bus.dst_waddr, 0);
        checkOutput({tag, "_dst_wdata"}, bus.dst_wdata, 0);
        checkOutput({tag, "_rop_P"}, bus.rop_P, 0);
        checkOutput({tag, "_rop_S"}, bus.rop_S, 0);
        checkOutput({tag, "_rop_D"}, bus.rop_D, 0);
        checkOutput({tag, "_rop_Mode"}, bus.rop_Mode, 0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int lat;
        logic [7:0] exp1 [4];
        logic [7:0] exp2 [3];

        for (int i = 0; i < 256; i++) begin
            src_mem[i] = 8'(i) ^ 8'h5C;
            dst_mem[i] = ~8'(i);
        end
        bus.start    = 1'b0;
        bus.abort    = 1'b0;
        bus.mode     = '0;
        bus.pattern  = '0;
        bus.src_base = '0;
        bus.dst_base = '0;
        bus.len      = '0;

        #2 rst_n = 1'b0;
        #1 checkResetState("reset");
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        checking = 1'b1;

        // Copy (mode CC): four words, done 8 cycles after start.
        src_mem[10] = 8'hA1; src_mem[11] = 8'hA2; src_mem[12] = 8'hA3; src_mem[13] = 8'hA4;
        exp1 = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
        applyStimulus(8'hCC, 8'h00, 8'd10, 8'd40, 8'd4);
        waitDone(40, lat);
        checkOutput("t1_latency", lat, 8);
        checkOutput("t1_words_done", bus.words_done, 4);
        for (int i = 0; i < 4; i++) checkOutput("t1_dst", dst_mem[40 + i], exp1[i]);

        // P xor D with pattern 0F.
        dst_mem[60] = 8'hF0; dst_mem[61] = 8'h3C; dst_mem[62] = 8'h00;
        exp2 = '{8'hFF, 8'h33, 8'h0F};
        applyStimulus(8'h5A, 8'h0F, 8'd100, 8'd60, 8'd3);
        waitDone(40, lat);
        checkOutput("t2_latency", lat, 7);
        for (int i = 0; i < 3; i++) checkOutput("t2_dst", dst_mem[60 + i], exp2[i]);

        // Zero-length command: done next cycle, no memory traffic.
        applyStimulus(8'hCC, 8'h00, 8'd0, 8'd0, 8'd0);
        waitDone(10, lat);
        checkOutput("t3_latency", lat, 1);
        checkOutput("t3_words_done", bus.words_done, 0);
        tick();
        tick();

        // Address wrap on both sides.
        src_mem[8'hFE] = 8'h11; src_mem[8'hFF] = 8'h22; src_mem[8'h00] = 8'h33;
        applyStimulus(8'hCC, 8'h00, 8'hFE, 8'hFF, 8'd3);
        waitDone(40, lat);
        checkOutput("t4_dst_ff", dst_mem[8'hFF], 8'h11);
        checkOutput("t4_dst_00", dst_mem[8'h00], 8'h22);
        checkOutput("t4_dst_01", dst_mem[8'h01], 8'h33);

        // Abort while index 5 is being issued: indices 0 and 1 already written.
        for (int i = 0; i < 10; i++) begin
            src_mem[150 + i] = 8'h70 + 8'(i);
            dst_mem[200 + i] = 8'hE0 + 8'(i);
        end
        applyStimulus(8'hCC, 8'h00, 8'd150, 8'd200, 8'd10);
        while (cyc < cmd_s + 6) tick();
        bus.abort = 1'b1;
        planAbort(cyc);
        tick();
        bus.abort = 1'b0;
        checkOutput("t5_done", bus.done, 1);
        checkOutput("t5_aborted", bus.aborted, 1);
        checkOutput("t5_words_done", bus.words_done, 2);
        tick();
        checkOutput("t5_words_hold", bus.words_done, 2);
        checkOutput("t5_dst_0", dst_mem[200], 8'h70);
        checkOutput("t5_dst_1", dst_mem[201], 8'h71);
        for (int i = 2; i < 10; i++) checkOutput("t5_dst_untouched", dst_mem[200 + i], 8'hE0 + 8'(i));

        // Abort in IDLE is ignored.
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        tick();

        // Mixed mode P^S^D with a pattern, checked against the model only.
        applyStimulus(8'h96, 8'h3C, 8'd48, 8'd144, 8'd5);
        waitDone(40, lat);
        checkOutput("t7_latency", lat, 9);

        // Start while busy is ignored; reset mid-RUN clears everything at once.
        applyStimulus(8'hCC, 8'h00, 8'd20, 8'd80, 8'd8);
        while (cyc < cmd_s + 3) tick();
        bus.len      = 8'd2;
        bus.src_base = 8'd0;
        bus.start    = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        rst_n = 1'b0;
        resetModel();
        #1 checkResetState("midrun");
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        src_mem[30] = 8'hC1; src_mem[31] = 8'hC2; src_mem[32] = 8'hC3;
        applyStimulus(8'hCC, 8'h00, 8'd30, 8'd120, 8'd3);
        waitDone(40, lat);
        checkOutput("t6_latency", lat, 7);
        checkOutput("t6_words_done", bus.words_done, 3);
        checkOutput("t6_dst_0", dst_mem[120], 8'hC1);
        checkOutput("t6_dst_1", dst_mem[121], 8'hC2);
        checkOutput("t6_dst_2", dst_mem[122], 8'hC3);

        tick();
        tick();
        checkOutput("pending_reads", rdq.size(), 0);
        checkOutput("pending_writes", wrq.size(), 0);
        checking = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
